univ_shift_reg_burst: RTL and testbench
=======================================

// Module: univ_shift_reg_burst
// PURPOSE
//   Parametrised universal shift register: hold, shift left/right, parallel load,
//   rotate, arithmetic shift right and clear, selected by a 3-bit mode code.
//   Adds a burst engine that performs a programmed number of serial shifts
//   autonomously, with busy/done handshake, for serialiser/deserialiser use.
//   Sits between parallel datapath registers and bit-serial links.
// PARAMETERS
//   WIDTH  8  register width in bits (>= 2)
//   CNT_W  4  width of burst length / remaining counter (max burst 2^CNT_W-1)
// PORTS
//   clk        in   1        clock; all state updates on rising edge
//   reset      in   1        reset, asynchronous, active-high
//   en         in   1        enables mode operation while IDLE
//   mode       in   3        operation select (see BEHAVIOUR)
//   par_in     in   WIDTH    parallel load data
//   sin_lsb    in   1        serial in, enters bit 0 on left shift
//   sin_msb    in   1        serial in, enters bit WIDTH-1 on right shift
//   start      in   1        burst request (sampled only while IDLE)
//   burst_len  in   CNT_W    number of shifts in burst
//   burst_dir  in   1        0 = left, 1 = right
//   q          out  WIDTH    register contents
//   sout_msb   out  1        q[WIDTH-1] (combinational from q)
//   sout_lsb   out  1        q[0] (combinational from q)
//   busy       out  1        high while in BURST state
//   done       out  1        one-cycle pulse at burst completion
//   remaining  out  CNT_W    shifts still to perform in current burst
// BEHAVIOUR
//   Reset (async, any state): q=0, state=IDLE, busy=0, done=0, remaining=0.
//   Left shift : q <= {q[WIDTH-2:0], sin_lsb};  right: q <= {sin_msb, q[WIDTH-1:1]}.
//   Mode codes (IDLE, en=1, start=0), applied at the rising edge:
//     000 hold | 001 shl | 010 shr | 011 load par_in | 100 rotl {q[W-2:0],q[W-1]}
//     101 rotr {q[0],q[W-1:1]} | 110 asr {q[W-1],q[W-1:1]} | 111 clear q=0
//   en=0 in IDLE: q holds regardless of mode.
//   FSM states: IDLE, BURST. busy = (state==BURST), registered.
//   IDLE, start=1: takes priority over en/mode; q unchanged this edge;
//     remaining <= burst_len; latch burst_dir; state <= BURST.
//   BURST, remaining != 0: shift q in latched direction using current sin_*,
//     remaining <= remaining-1.
//   BURST, remaining == 0: no shift; state <= IDLE; done <= 1 for one cycle.
//   Burst of N shifts: busy high N+1 cycles; done high the cycle after busy falls.
//   burst_len=0: busy high 1 cycle, q unchanged, done pulses normally.
//   In BURST: en, mode, start, burst_len, burst_dir ignored (start is not queued).
//   done is cleared every cycle except the completion cycle; start in the
//     cycle done=1 is accepted (back-to-back bursts allowed).
//   Reset mid-burst: aborts immediately, all outputs to reset values, no done.
//   Serial inputs are sampled each shift cycle, not latched at start.
// TESTING
//   Reset then mode=011 par_in=0xA5 en=1 -> q=0xA5; en=0 with mode=001 -> q stays 0xA5.
//   q=0xA5, mode=001 sin_lsb=1 -> q=0x4B; mode=010 sin_msb=0 -> q=0x25.
//   q=0x81: mode=100 -> 0x03; q=0x81: mode=101 -> 0xC0; q=0x80: mode=110 -> 0xC0; mode=111 -> 0x00.
//   q=0x0F, start burst_len=3 dir=0 sin_lsb=0 -> busy 4 cycles, remaining 3,2,1,0,
//     q=0x78, done one cycle; mode changes during burst have no effect.
//   burst_len=0 -> busy 1 cycle, q unchanged, done pulse; start on done cycle -> new burst.
//   Assert reset during burst (remaining=2) -> q=0, busy=0, done=0 immediately, no later done.

Source files
------------

// File: rtl/univ_shift_reg_burst.sv
// ---------------------------------------------------------------------------
// univ_shift_reg_burst
//
// Universal shift register with an autonomous burst-shift engine. It sits
// between parallel datapath registers and bit-serial links.
//
// While IDLE and enabled, a 3-bit mode code selects one operation per clock:
// hold, shift left, shift right, parallel load, rotate left, rotate right,
// arithmetic shift right, or clear.
//
// A start request (honoured only while IDLE) begins a burst. The burst
// performs burst_len_i serial shifts in the direction latched at start. busy_o
// reports the burst, and done_o pulses for one cycle when the burst finishes.
//
// Ports:
//   clk_i        clock, rising edge
//   reset_i      asynchronous, active-high reset
//   en_i         enables mode operation while IDLE
//   mode_i       operation select
//   par_in_i     parallel load data
//   sin_lsb_i    serial in, enters bit 0 on a left shift
//   sin_msb_i    serial in, enters bit WIDTH-1 on a right shift
//   start_i      burst request (IDLE only, not queued while busy)
//   burst_len_i  number of shifts in the burst
//   burst_dir_i  burst direction: 0 = left, 1 = right
//   q_o          register contents
//   sout_msb_o   q_o[WIDTH-1]
//   sout_lsb_o   q_o[0]
//   busy_o       high while the burst engine is active
//   done_o       one-cycle pulse at burst completion
//   remaining_o  shifts still to perform in the current burst
// ---------------------------------------------------------------------------
module univ_shift_reg_burst #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic [2:0]       mode_i,
  input  logic [WIDTH-1:0] par_in_i,
  input  logic             sin_lsb_i,
  input  logic             sin_msb_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] burst_len_i,
  input  logic             burst_dir_i,
  output logic [WIDTH-1:0] q_o,
  output logic             sout_msb_o,
  output logic             sout_lsb_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] remaining_o
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHL  = 3'b001;
  localparam logic [2:0] M_SHR  = 3'b010;
  localparam logic [2:0] M_LOAD = 3'b011;
  localparam logic [2:0] M_ROTL = 3'b100;
  localparam logic [2:0] M_ROTR = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;
  localparam logic [2:0] M_CLR  = 3'b111;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;

  // Candidate results of every shift/rotate. The same left/right shifts
  // serve both mode operation and burst steps.
  logic [WIDTH-1:0] shl_w, shr_w, rotl_w, rotr_w, asr_w;

  assign shl_w  = {q_q[WIDTH-2:0], sin_lsb_i};
  assign shr_w  = {sin_msb_i, q_q[WIDTH-1:1]};
  assign rotl_w = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
  assign rotr_w = {q_q[0], q_q[WIDTH-1:1]};
  assign asr_w  = {q_q[WIDTH-1], q_q[WIDTH-1:1]};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      q_q         <= '0;
      remaining_q <= '0;
      dir_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      remaining_q <= remaining_d;
      dir_q       <= dir_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    q_d         = q_q;
    remaining_d = remaining_q;
    dir_d       = dir_q;
    // done is a single-cycle pulse, so it is cleared unless completion is reached.
    done_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          // start wins over en/mode; q is left untouched on the accepting edge.
          remaining_d = burst_len_i;
          dir_d       = burst_dir_i;
          state_d     = S_BURST;
        end else if (en_i) begin
          unique case (mode_i)
            M_HOLD:  q_d = q_q;
            M_SHL:   q_d = shl_w;
            M_SHR:   q_d = shr_w;
            M_LOAD:  q_d = par_in_i;
            M_ROTL:  q_d = rotl_w;
            M_ROTR:  q_d = rotr_w;
            M_ASR:   q_d = asr_w;
            M_CLR:   q_d = '0;
            default: q_d = q_q;
          endcase
        end
      end
      S_BURST: begin
        if (remaining_q != '0) begin
          // Serial inputs are taken live on each step, not captured at start.
          q_d         = dir_q ? shr_w : shl_w;
          remaining_d = remaining_q - CNT_ONE;
        end else begin
          // A terminal cycle with no shift gives N+1 busy cycles for N shifts.
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign q_o         = q_q;
  assign sout_msb_o  = q_q[WIDTH-1];
  assign sout_lsb_o  = q_q[0];
  assign busy_o      = (state_q == S_BURST);
  assign done_o      = done_q;
  assign remaining_o = remaining_q;

endmodule

// File: tb/tb_univ_shift_reg_burst.sv
module tb_univ_shift_reg_burst;

  localparam int W = 8;
  localparam int C = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic [2:0]   mode;
  logic [W-1:0] par_in;
  logic         sin_lsb, sin_msb;
  logic         start;
  logic [C-1:0] burst_len;
  logic         burst_dir;
  logic [W-1:0] q;
  logic         sout_msb, sout_lsb, busy, done;
  logic [C-1:0] remaining;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  univ_shift_reg_burst #(.WIDTH(W), .CNT_W(C)) dut (
    .clk_i(clk), .reset_i(reset), .en_i(en), .mode_i(mode),
    .par_in_i(par_in), .sin_lsb_i(sin_lsb), .sin_msb_i(sin_msb),
    .start_i(start), .burst_len_i(burst_len), .burst_dir_i(burst_dir),
    .q_o(q), .sout_msb_o(sout_msb), .sout_lsb_o(sout_lsb),
    .busy_o(busy), .done_o(done), .remaining_o(remaining)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string nm, input logic [W-1:0] eq, input logic eb,
                         input logic ed, input logic [C-1:0] er);
    chk({nm, ".q"}, 32'(q), 32'(eq));
    chk({nm, ".busy"}, 32'(busy), 32'(eb));
    chk({nm, ".done"}, 32'(done), 32'(ed));
    chk({nm, ".remaining"}, 32'(remaining), 32'(er));
  endtask

  // Behavioural reference: plain arithmetic on integers.
  int  m_q, m_rem, m_busy, m_done, m_dir;
  localparam int MASK = (1 << W) - 1;
  localparam int TOP  = 1 << (W - 1);

  function automatic int mode_result(int cur, int md, int par, int sl, int sm);
    case (md)
      0: return cur;
      1: return ((cur << 1) | sl) & MASK;
      2: return (cur >> 1) | (sm ? TOP : 0);
      3: return par & MASK;
      4: return ((cur << 1) & MASK) | ((cur & TOP) ? 1 : 0);
      5: return (cur >> 1) | ((cur & 1) ? TOP : 0);
      6: return (cur >> 1) | (cur & TOP);
      default: return 0;
    endcase
  endfunction

  task automatic model_edge();
    if (m_busy == 0) begin
      m_done = 0;
      if (start) begin
        m_rem  = int'(burst_len);
        m_dir  = int'(burst_dir);
        m_busy = 1;
      end else if (en) begin
        m_q = mode_result(m_q, int'(mode), int'(par_in), int'(sin_lsb), int'(sin_msb));
      end
    end else if (m_rem > 0) begin
      m_q    = mode_result(m_q, m_dir ? 2 : 1, 0, int'(sin_lsb), int'(sin_msb));
      m_rem  = m_rem - 1;
      m_done = 0;
    end else begin
      m_busy = 0;
      m_done = 1;
    end
  endtask

  typedef struct {
    string        name;
    logic         en;
    logic [2:0]   mode;
    logic [W-1:0] par;
    logic         sl;
    logic         sm;
    logic [W-1:0] exp_q;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{"load_a5",  1'b1, 3'b011, 8'hA5, 1'b0, 1'b0, 8'hA5};
    vecs[1]  = '{"en0_hold", 1'b0, 3'b001, 8'h00, 1'b1, 1'b1, 8'hA5};
    vecs[2]  = '{"shl",      1'b1, 3'b001, 8'h00, 1'b1, 1'b0, 8'h4B};
    vecs[3]  = '{"shr",      1'b1, 3'b010, 8'h00, 1'b1, 1'b0, 8'h25};
    vecs[4]  = '{"load_81",  1'b1, 3'b011, 8'h81, 1'b0, 1'b0, 8'h81};
    vecs[5]  = '{"rotl",     1'b1, 3'b100, 8'h00, 1'b0, 1'b0, 8'h03};
    vecs[6]  = '{"load_81b", 1'b1, 3'b011, 8'h81, 1'b0, 1'b0, 8'h81};
    vecs[7]  = '{"rotr",     1'b1, 3'b101, 8'h00, 1'b0, 1'b0, 8'hC0};
    vecs[8]  = '{"load_80",  1'b1, 3'b011, 8'h80, 1'b0, 1'b0, 8'h80};
    vecs[9]  = '{"asr",      1'b1, 3'b110, 8'h00, 1'b0, 1'b0, 8'hC0};
    vecs[10] = '{"hold",     1'b1, 3'b000, 8'h00, 1'b1, 1'b1, 8'hC0};
    vecs[11] = '{"clear",    1'b1, 3'b111, 8'hFF, 1'b1, 1'b1, 8'h00};

    reset = 1'b1; en = 1'b0; mode = 3'b000; par_in = '0;
    sin_lsb = 1'b0; sin_msb = 1'b0; start = 1'b0; burst_len = '0; burst_dir = 1'b0;
    step(); step();
    chk_all("reset", 8'h00, 1'b0, 1'b0, 4'd0);
    reset = 1'b0;
    step();

    // Table-driven mode operations.
    for (int i = 0; i < 12; i++) begin
      en = vecs[i].en; mode = vecs[i].mode; par_in = vecs[i].par;
      sin_lsb = vecs[i].sl; sin_msb = vecs[i].sm;
      step();
      $display("vec %s: q=%02h", vecs[i].name, q);
      chk(vecs[i].name, 32'(q), 32'(vecs[i].exp_q));
      chk({vecs[i].name, ".sout_msb"}, 32'(sout_msb), 32'(vecs[i].exp_q[W-1]));
      chk({vecs[i].name, ".sout_lsb"}, 32'(sout_lsb), 32'(vecs[i].exp_q[0]));
    end

    // Burst of 3 left shifts from 0x0F; mode activity during the burst is ignored.
    en = 1'b1; mode = 3'b011; par_in = 8'h0F; step();
    start = 1'b1; burst_len = 4'd3; burst_dir = 1'b0; sin_lsb = 1'b0; step();
    $display("burst len=3 dir=left");
    chk_all("b3.accept", 8'h0F, 1'b1, 1'b0, 4'd3);
    start = 1'b1; burst_len = 4'd9; burst_dir = 1'b1; mode = 3'b111;
    step(); chk_all("b3.s1", 8'h1E, 1'b1, 1'b0, 4'd2);
    start = 1'b0; mode = 3'b011;
    step(); chk_all("b3.s2", 8'h3C, 1'b1, 1'b0, 4'd1);
    step(); chk_all("b3.s3", 8'h78, 1'b1, 1'b0, 4'd0);
    en = 1'b0;
    step(); chk_all("b3.done", 8'h78, 1'b0, 1'b1, 4'd0);
    step(); chk_all("b3.after", 8'h78, 1'b0, 1'b0, 4'd0);

    // burst_len=0, then a back-to-back start in the done cycle.
    start = 1'b1; burst_len = 4'd0; step();
    $display("burst len=0");
    chk_all("b0.accept", 8'h78, 1'b1, 1'b0, 4'd0);
    start = 1'b0; step();
    chk_all("b0.done", 8'h78, 1'b0, 1'b1, 4'd0);
    start = 1'b1; burst_len = 4'd2; burst_dir = 1'b1; sin_msb = 1'b1; step();
    $display("burst len=2 dir=right (back-to-back)");
    chk_all("b2b.accept", 8'h78, 1'b1, 1'b0, 4'd2);
    start = 1'b0;

    // Asynchronous reset in mid-burst with remaining=2.
    reset = 1'b1; #1;
    chk_all("rst_mid", 8'h00, 1'b0, 1'b0, 4'd0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_all("rst_nodone", 8'h00, 1'b0, 1'b0, 4'd0);
    end

    // Randomised traffic against the reference model.
    m_q = 0; m_rem = 0; m_busy = 0; m_done = 0; m_dir = 0;
    for (int i = 0; i < 400; i++) begin
      en        = 1'($urandom_range(0, 3) != 0);
      mode      = 3'($urandom);
      par_in    = 8'($urandom);
      sin_lsb   = 1'($urandom);
      sin_msb   = 1'($urandom);
      start     = 1'($urandom_range(0, 7) == 0);
      burst_len = 4'($urandom);
      burst_dir = 1'($urandom);
      if (start && m_busy == 0)
        $display("rand %0d: burst len=%0d dir=%0d", i, burst_len, burst_dir);
      model_edge();
      step();
      chk_all("rand", 8'(m_q), 1'(m_busy), 1'(m_done), 4'(m_rem));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
